iir_1pole_mac: RTL and testbench

IIR_1POLE_MAC -- requirements
Module: iir_1pole_mac

---
 rtl/iir_pkg.sv | 17 +
 rtl/iir_mac.sv | 64 ++++++
 rtl/iir_1pole_mac.sv | 130 +++++++++++++
 tb/tb_iir_1pole_mac.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared widths, fixed-point shift and FSM states for the one-pole IIR MAC
package iir_pkg;
  localparam int DATA_W     = 8;
  localparam int COEF_W     = 8;
  localparam int OUT_W      = 16;
  localparam int ACC_W      = 26;
  localparam int FRAC_SHIFT = 6;
  localparam int PROD_W     = COEF_W + OUT_W;

  typedef enum logic [2:0] {
    IDLE,
    MB0,
    MB1,
    MA1,
    OUT
  } state_t;
endpackage

// File: rtl/iir_mac.sv
// rtl/iir_mac.sv - shared signed multiplier with operand select and 26-bit accumulator
module iir_mac
  import iir_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  state_t                  phase,
  input  logic [COEF_W-1:0]       b0,
  input  logic [COEF_W-1:0]       b1,
  input  logic [COEF_W-1:0]       a1,
  input  logic [DATA_W-1:0]       x,
  input  logic [DATA_W-1:0]       x_prev,
  input  logic [OUT_W-1:0]        y_prev,
  output logic signed [ACC_W-1:0] acc_next
);

  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  base;
  logic signed [COEF_W-1:0] coef;
  logic signed [OUT_W-1:0]  operand;
  logic signed [PROD_W-1:0] prod;

  always_comb begin
    coef    = '0;
    operand = '0;
    base    = acc_q;
    acc_d   = acc_q;
    case (phase)
      MB0: begin
        coef    = b0;
        operand = OUT_W'($signed(x));
        base    = '0;
      end
      MB1: begin
        coef    = b1;
        operand = OUT_W'($signed(x_prev));
      end
      MA1: begin
        coef    = a1;
        operand = y_prev;
      end
      default: ;
    endcase
    prod = coef * operand;
    // The feedback term enters with a minus sign: y = ... - A1*y[n-1].
    case (phase)
      MB0, MB1: acc_d = base + ACC_W'(prod);
      MA1:      acc_d = base - ACC_W'(prod);
      default:  acc_d = acc_q;
    endcase
  end

  assign acc_next = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/iir_1pole_mac.sv
// rtl/iir_1pole_mac.sv - one-pole IIR, one shared MAC over 5 states; IIR_SAT_EN selects clamp instead of wrap
module iir_1pole_mac
  import iir_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] Xin,
  input  logic [COEF_W-1:0] B0,
  input  logic [COEF_W-1:0] B1,
  input  logic [COEF_W-1:0] A1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  Yout
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   x_q, x_d;
  logic [COEF_W-1:0]   b0_q, b0_d;
  logic [COEF_W-1:0]   b1_q, b1_d;
  logic [COEF_W-1:0]   a1_q, a1_d;
  logic [DATA_W-1:0]   x_prev_q, x_prev_d;
  logic [OUT_W-1:0]    y_prev_q, y_prev_d;
  logic [OUT_W-1:0]    yout_q, yout_d;
  logic                out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0] acc_next;
  logic [OUT_W-1:0]    y_res;

  iir_mac u_mac (
    .clk      (clk),
    .rst      (rst),
    .phase    (state_q),
    .b0       (b0_q),
    .b1       (b1_q),
    .a1       (a1_q),
    .x        (x_q),
    .x_prev   (x_prev_q),
    .y_prev   (y_prev_q),
    .acc_next (acc_next)
  );

`ifdef IIR_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = -Y_MAX - ACC_W'(1);
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc_next >>> FRAC_SHIFT;
    if (shifted > Y_MAX) begin
      y_res = Y_MAX[OUT_W-1:0];
    end else if (shifted < Y_MIN) begin
      y_res = Y_MIN[OUT_W-1:0];
    end else begin
      y_res = shifted[OUT_W-1:0];
    end
  end
`else
  assign y_res = OUT_W'(acc_next >>> FRAC_SHIFT);
`endif

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    a1_d        = a1_q;
    x_prev_d    = x_prev_q;
    y_prev_d    = y_prev_q;
    yout_d      = yout_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = Xin;
          b0_d    = B0;
          b1_d    = B1;
          a1_d    = A1;
          state_d = MB0;
        end
      end
      MB0: state_d = MB1;
      MB1: state_d = MA1;
      MA1: begin
        yout_d      = y_res;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        // History advances only when the consumer actually takes the result.
        if (out_ready) begin
          x_prev_d    = x_q;
          y_prev_d    = yout_q;
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      a1_q        <= '0;
      x_prev_q    <= '0;
      y_prev_q    <= '0;
      yout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      a1_q        <= a1_d;
      x_prev_q    <= x_prev_d;
      y_prev_q    <= y_prev_d;
      yout_q      <= yout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign Yout      = yout_q;

endmodule

// File: tb/tb_iir_1pole_mac.sv
// tb/tb_iir_1pole_mac.sv - directed self-checking bench for iir_1pole_mac
module tb_iir_1pole_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  Xin = '0;
  logic [7:0]  B0 = '0;
  logic [7:0]  B1 = '0;
  logic [7:0]  A1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] Yout;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] last_y = '0;

  iir_1pole_mac dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Xin       (Xin),
    .B0        (B0),
    .B1        (B1),
    .A1        (A1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Yout      (Yout)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d (0x%h) expected=%0d (0x%h)", tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    last_y = '0;
  endtask

  task automatic do_sample(input logic [7:0] x, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] a1, input logic [15:0] exp_y, input string tag);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      step();
      waited++;
    end
    chk({tag, "_in_ready"}, 16'(in_ready), 16'd1);
    Xin = x;
    B0 = b0;
    B1 = b1;
    A1 = a1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk({tag, "_ov_ma1"}, 16'(out_valid), 16'd0);
    chk({tag, "_yhold"}, Yout, last_y);
    step();
    chk({tag, "_ov_out"}, 16'(out_valid), 16'd1);
    chk({tag, "_y"}, Yout, exp_y);
    last_y = exp_y;
    step();
  endtask

  initial begin
    int e;

    // Reset state
    step();
    step();
    chk("rst_in_ready", 16'(in_ready), 16'd0);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_yout", Yout, 16'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 16'(in_ready), 16'd1);

    // Impulse: 64, 32, 16, 8
    do_sample(8'd64, 8'd64, 8'd0, -8'sd32, 16'd64, "imp0");
    do_sample(8'd0,  8'd64, 8'd0, -8'sd32, 16'd32, "imp1");
    do_sample(8'd0,  8'd64, 8'd0, -8'sd32, 16'd16, "imp2");
    do_sample(8'd0,  8'd64, 8'd0, -8'sd32, 16'd8,  "imp3");

    // FIR-only: 10, 30
    do_reset();
    do_sample(8'd10, 8'd64, 8'd64, 8'd0, 16'd10, "fir0");
    do_sample(8'd20, 8'd64, 8'd64, 8'd0, 16'd30, "fir1");

    // Backpressure: x=5 gives (320 + 64*20) >>> 6 = 25
    out_ready = 1'b0;
    Xin = 8'd5;
    B0 = 8'd64;
    B1 = 8'd64;
    A1 = 8'd0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    chk("bp_ov_enter", 16'(out_valid), 16'd1);
    chk("bp_y_enter", Yout, 16'd25);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_ov_hold", 16'(out_valid), 16'd1);
      chk("bp_in_ready_hold", 16'(in_ready), 16'd0);
      chk("bp_y_hold", Yout, 16'd25);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_deliver_ov", 16'(out_valid), 16'd1);
    step();
    chk("bp_after_ov", 16'(out_valid), 16'd0);
    chk("bp_after_in_ready", 16'(in_ready), 16'd1);
    last_y = 16'd25;
    // History updated exactly once: (0 + 64*5) >>> 6 = 5
    do_sample(8'd0, 8'd64, 8'd64, 8'd0, 16'd5, "bp_next");

    // Mid-operation reset in MB1, with non-zero history present
    do_reset();
    do_sample(8'd64, 8'd64, 8'd0, -8'sd32, 16'd64, "mr_pre0");
    do_sample(8'd0,  8'd64, 8'd0, -8'sd32, 16'd32, "mr_pre1");
    Xin = 8'd64;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("mr_ov", 16'(out_valid), 16'd0);
    chk("mr_in_ready_rst", 16'(in_ready), 16'd0);
    chk("mr_yout", Yout, 16'd0);
    rst = 1'b0;
    #1;
    chk("mr_in_ready_rel", 16'(in_ready), 16'd1);
    last_y = '0;
    // With stale y[n-1]=32 this would be 64+16; zero history gives 64.
    do_sample(8'd64, 8'd64, 8'd0, -8'sd32, 16'd64, "mr_post");

    // Coefficient/sample change after accept must not affect the sample in flight
    // History now x1=64, y1=64; in-flight B1=A1=0 so y = 64*10 >>> 6 = 10
    Xin = 8'd10;
    B0 = 8'd64;
    B1 = 8'd0;
    A1 = 8'd0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    Xin = 8'd100;
    B0 = 8'd0;
    B1 = 8'd64;
    A1 = -8'sd64;
    step();
    step();
    B0 = 8'd0;
    step();
    chk("cc_ov", 16'(out_valid), 16'd1);
    chk("cc_y", Yout, 16'd10);
    step();
    last_y = 16'd10;

    // Saturation / wrap: y[n] = 252 + 504*n until overflow at n=65
    do_reset();
    for (int n = 0; n <= 66; n++) begin
      if (n <= 64) begin
        e = 252 + 504 * n;
      end else begin
`ifdef IIR_SAT_EN
        e = 32767;
`else
        e = (n == 65) ? -32524 : -32020;
`endif
      end
      do_sample(8'd127, 8'd127, 8'd127, -8'sd64, 16'(e), $sformatf("sat%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
